// File: rtl/riscv_multi_ctrl.sv
// Purpose : multicycle RISC-V control FSM sequencing one shared ALU/memory per instruction.
// Latency : beq 3, sw/R/I/jal 4, lw 5 cycles (plus memory wait cycles when MEM_WAIT_EN=1).
// Backpr. : with MEM_WAIT_EN=1, FETCH/MEMRD/MEMWR hold until mem_ready; otherwise never stalls.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   opcode, funct3, funct7b5      instruction fields from the IR
//   zero                          ALU result == 0 (branch decision)
//   mem_ready                     memory access complete (only with MEM_WAIT_EN=1)
//   pc_we, ir_we, mem_we, reg_we  datapath write enables (all forced low during rst)
//   adr_src, imm_src, alu_src_a,  datapath mux selects and ALU operation
//   alu_src_b, alu_ctrl, res_src
//   instr_done, illegal           final-cycle marker and unsupported-opcode pulse
//   state                         current FSM state (debug)
module riscv_multi_ctrl #(
    parameter bit MEM_WAIT_EN = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       adr_src,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] imm_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] res_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXER   = 4'd6,
        S_EXEI   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BEQ    = 4'd9,
        S_JAL    = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t state_q, state_d;

    // Raw enables before the reset gate.
    logic pc_we_c, ir_we_c, mem_we_c, reg_we_c, done_c, illegal_c;
    logic mem_rdy;
    logic [2:0] alu_dec;

    // Without the wait handshake the memory is treated as always ready.
    assign mem_rdy = !MEM_WAIT_EN || mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU operation for R/I-type execute; subtract only exists for R-type.
    always_comb begin
        alu_dec = ALU_ADD;
        case (funct3)
            3'b000:  alu_dec = (state_q == S_EXER && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_dec = ALU_SLT;
            3'b100:  alu_dec = ALU_XOR;
            3'b110:  alu_dec = ALU_OR;
            3'b111:  alu_dec = ALU_AND;
            default: alu_dec = ALU_ADD;
        endcase
    end

    always_comb begin
        imm_src = 2'b00;
        case (opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_we_c   = 1'b0;
        ir_we_c   = 1'b0;
        mem_we_c  = 1'b0;
        reg_we_c  = 1'b0;
        done_c    = 1'b0;
        illegal_c = 1'b0;
        adr_src   = 1'b0;
        alu_src_a = 2'b00;
        alu_src_b = 2'b00;
        alu_ctrl  = ALU_ADD;
        res_src   = 2'b00;

        case (state_q)
            S_FETCH: begin
                // PC+4 goes straight from the ALU into the PC.
                alu_src_b = 2'b10;
                res_src   = 2'b10;
                ir_we_c   = mem_rdy;
                pc_we_c   = mem_rdy;
                if (mem_rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                // Branch target computed speculatively into the ALU-out register.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXER;
                    OP_I:         state_d = S_EXEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
                if (mem_rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                res_src  = 2'b01;
                reg_we_c = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                // Write strobe stays up for the whole access; done only on completion.
                adr_src  = 1'b1;
                mem_we_c = 1'b1;
                done_c   = mem_rdy;
                if (mem_rdy) state_d = S_FETCH;
            end
            S_EXER: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_dec;
                state_d   = S_ALUWB;
            end
            S_EXEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_dec;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_we_c = 1'b1;
                done_c   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BEQ: begin
                // PC loads the target held in ALU-out when rs1-rs2 == 0.
                alu_src_a = 2'b10;
                alu_ctrl  = ALU_SUB;
                pc_we_c   = zero;
                done_c    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                // Jump target already in ALU-out from DECODE; ALU forms old PC+4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_we_c   = 1'b1;
                state_d   = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset wins combinationally so no write escapes while rst is high.
    assign pc_we      = pc_we_c   & ~rst;
    assign ir_we      = ir_we_c   & ~rst;
    assign mem_we     = mem_we_c  & ~rst;
    assign reg_we     = reg_we_c  & ~rst;
    assign instr_done = done_c    & ~rst;
    assign illegal    = illegal_c & ~rst;
    assign state      = state_q;

endmodule
